// File: rtl/alu_pipe.sv
// alu_pipe: pipelined 8-operation ALU with status flags and a valid/ready
// handshake. Stage 1 evaluates the operation; the remaining stages only delay
// the result. Flow control is stall-all: the whole pipe advances together
// whenever the output register is empty or being drained.
module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6,
    parameter int N_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_op_1,
    input  logic [NB_DATA-1:0]   i_op_2,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_zero,
    output logic                 o_neg,
    output logic                 o_carry,
    output logic                 o_ovf,
    output logic                 o_err
);

    localparam int MSB = NB_DATA - 1;

    // Opcode map inherited from the original combinational ALU.
    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);

    // Shift amounts at or above the data width saturate.
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    // One pipeline slot: result plus every flag that travels with it.
    typedef struct packed {
        logic [NB_DATA-1:0] result;
        logic               zero;
        logic               neg;
        logic               carry;
        logic               ovf;
        logic               err;
    } stage_t;

    // Evaluate one operation. Illegal opcodes yield result 0 with err set;
    // zero/neg are always derived from the final result.
    function automatic stage_t alu_eval(
        input logic [NB_DATA-1:0]   a,
        input logic [NB_DATA-1:0]   b,
        input logic [NB_OPCODE-1:0] op
    );
        stage_t           r;
        logic [NB_DATA:0] wide;
        logic             big;
        r    = '0;
        wide = '0;
        big  = (b >= SHIFT_LIMIT);
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                r.result = wide[MSB:0];
                r.carry  = wide[NB_DATA];
                r.ovf    = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of an unsigned subtract is the borrow.
                wide     = {1'b0, a} - {1'b0, b};
                r.result = wide[MSB:0];
                r.carry  = wide[NB_DATA];
                r.ovf    = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_AND: r.result = a & b;
            OP_OR:  r.result = a | b;
            OP_XOR: r.result = a ^ b;
            OP_NOR: r.result = ~(a | b);
            OP_SRA: r.result = big ? {NB_DATA{a[MSB]}} : NB_DATA'($signed(a) >>> b);
            OP_SRL: r.result = big ? {NB_DATA{1'b0}} : (a >> b);
            default: begin
                r.result = '0;
                r.err    = 1'b1;
            end
        endcase
        r.zero = (r.result == '0);
        r.neg  = r.result[MSB];
        return r;
    endfunction

    logic [N_STAGES-1:0] stage_valid;
    stage_t              stage_data [N_STAGES];
    stage_t              stage_in;
    logic                adv;

    // The pipe moves when the last slot is empty or is being accepted.
    assign adv     = ~stage_valid[N_STAGES-1] | i_ready;
    assign o_ready = adv;

    // Stage-1 input: bubbles carry all-zero data so no flag leaks out.
    always_comb begin
        stage_in = '0;
        if (i_valid) begin
            stage_in = alu_eval(i_op_1, i_op_2, i_opcode);
        end else begin
            stage_in = '0;
        end
    end

    // Pipeline registers: flush on reset, shift together on adv, else hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stage_valid <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else if (adv) begin
            stage_valid[0] <= i_valid;
            stage_data[0]  <= stage_in;
            for (int i = 1; i < N_STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end else begin
            stage_valid <= stage_valid;
            for (int i = 0; i < N_STAGES; i++) begin
                stage_data[i] <= stage_data[i];
            end
        end
    end

    // Outputs come straight from the last pipeline register.
    assign o_valid  = stage_valid[N_STAGES-1];
    assign o_result = stage_data[N_STAGES-1].result;
    assign o_zero   = stage_data[N_STAGES-1].zero;
    assign o_neg    = stage_data[N_STAGES-1].neg;
    assign o_carry  = stage_data[N_STAGES-1].carry;
    assign o_ovf    = stage_data[N_STAGES-1].ovf;
    assign o_err    = stage_data[N_STAGES-1].err;

endmodule
